irq_status_ctrl: RTL and testbench

- Interrupt sequencer that owns all hardware-initiated updates to the CPU status register (status_t) and to PC.
- Prioritises level-sensitive IRQ lines and takes an interrupt at an instruction boundary when unmasked.
- On entry, saves status and PC into shadow registers, then forces SUPERVISOR mode with imask set and vectors PC.
- On return-from-interrupt (rti), restores both. Sits beside the register file and control unit, and stalls the core while sequencing.

---
 rtl/alu_pkg.sv | 11 +
 rtl/irq_pkg.sv | 18 +
 rtl/reg_pkg.sv | 16 +
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_status_ctrl.sv | 131 +++++++++++++
 tb/tb_irq_status_ctrl.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// ALU-side types shared with the status register.
package alu_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_status_t;

endpackage

// File: rtl/irq_pkg.sv
// Interrupt sequencer states, default vector layout and index width helper.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VECTOR  = 2'd1,
      RESTORE = 2'd2
   } irq_state_e;

   localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0010;
   localparam int          DEF_VECTOR_STRIDE = 4;

   // A single request line still needs a one-bit index.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_pkg.sv
// CPU status register layout and processor modes.
package reg_pkg;
   import alu_pkg::*;

   typedef enum logic {
      USER       = 1'b0,
      SUPERVISOR = 1'b1
   } cpu_mode_e;

   typedef struct packed {
      alu_status_t alu_status;
      logic        imask;
      cpu_mode_e   mode;
   } status_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; reports index and one-hot of the winner.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   localparam int IDW    = id_width(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [IDW-1:0]     index,
   output logic [NUM_IRQ-1:0] onehot
);

   always_comb begin
      valid  = |req;
      index  = '0;
      onehot = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            index     = IDW'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_status_ctrl.sv
// Interrupt sequencer: saves/restores status and PC around a single-level
// interrupt handler and stalls the core while it writes them.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | watching for a take at a boundary or an rti from the core
//   VECTOR  | writing supervisor status and the vector PC
//   RESTORE | writing back the saved status and PC, dropping the context
module irq_status_ctrl
   import reg_pkg::*;
   import irq_pkg::*;
#(
   parameter int          NUM_IRQ       = 8,
   parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
   parameter int          VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               boundary_i,
   input  logic               rti_i,
   input  status_t            status_i,
   input  logic [31:0]        pc_i,
   output status_t            status_o,
   output logic               status_we_o,
   output logic [31:0]        pc_o,
   output logic               pc_we_o,
   output logic               stall_o,
   output logic [NUM_IRQ-1:0] irq_ack_o,
   output logic               in_handler_o,
   output logic               rti_err_o
);

   localparam int IDW = id_width(NUM_IRQ);

   irq_state_e         state_q, state_d;
   status_t            saved_status_q;
   logic [31:0]        saved_pc_q;
   logic               saved_valid_q;
   logic [IDW-1:0]     id_q;

   logic               win_valid;
   logic [IDW-1:0]     win_index;
   logic [NUM_IRQ-1:0] win_onehot;
   logic               take;
   logic               rti_live;
   logic [31:0]        vec_pc;

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .req    (irq_i),
      .valid  (win_valid),
      .index  (win_index),
      .onehot (win_onehot)
   );

   // Gated by rst_n so nothing is acknowledged or flagged while held in reset.
   assign rti_live = rst_n & rti_i;
   assign take     = rst_n & (state_q == IDLE) & boundary_i & win_valid &
                     ~status_i.imask & ~saved_valid_q & ~rti_i;
   assign vec_pc   = VECTOR_BASE + (32'(id_q) * 32'(VECTOR_STRIDE));
   assign in_handler_o = saved_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stall_o     = 1'b0;
      status_we_o = 1'b0;
      pc_we_o     = 1'b0;
      status_o    = '0;
      pc_o        = '0;
      irq_ack_o   = '0;
      rti_err_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rti_live && saved_valid_q) begin
               stall_o = 1'b1;
               state_d = RESTORE;
            end else if (rti_live) begin
               rti_err_o = 1'b1;
            end else if (take) begin
               stall_o   = 1'b1;
               irq_ack_o = win_onehot;
               state_d   = VECTOR;
            end
         end
         VECTOR: begin
            stall_o     = 1'b1;
            status_we_o = 1'b1;
            pc_we_o     = 1'b1;
            status_o    = '{alu_status: saved_status_q.alu_status,
                            imask:      1'b1,
                            mode:       SUPERVISOR};
            pc_o        = vec_pc;
            state_d     = IDLE;
         end
         RESTORE: begin
            stall_o     = 1'b1;
            status_we_o = 1'b1;
            pc_we_o     = 1'b1;
            status_o    = saved_status_q;
            pc_o        = saved_pc_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         saved_status_q <= '0;
         saved_pc_q     <= '0;
         saved_valid_q  <= 1'b0;
         id_q           <= '0;
      end else if (take) begin
         saved_status_q <= status_i;
         saved_pc_q     <= pc_i;
         saved_valid_q  <= 1'b1;
         id_q           <= win_index;
      end else if (state_q == RESTORE) begin
         saved_valid_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_irq_status_ctrl.sv
// Bench for irq_status_ctrl: directed vector table, reset corner case and a
// randomized run against a queue-based reference model.
module tb_irq_status_ctrl;
   import alu_pkg::*;
   import reg_pkg::*;

   localparam logic [31:0] VB  = 32'h0000_0010;
   localparam logic [31:0] VBW = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  irq;
   logic        bnd;
   logic        rti;
   status_t     st_in;
   logic [31:0] pc_in;

   status_t     st_out, st_out_w;
   logic [31:0] pc_out, pc_out_w;
   logic        swe, pwe, stall, ih, err;
   logic        swe_w, pwe_w, stall_w, ih_w, err_w;
   logic [7:0]  ack, ack_w;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   irq_status_ctrl #(.NUM_IRQ(8), .VECTOR_BASE(VB), .VECTOR_STRIDE(4)) dut (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .boundary_i(bnd), .rti_i(rti),
      .status_i(st_in), .pc_i(pc_in), .status_o(st_out), .status_we_o(swe),
      .pc_o(pc_out), .pc_we_o(pwe), .stall_o(stall), .irq_ack_o(ack),
      .in_handler_o(ih), .rti_err_o(err));

   irq_status_ctrl #(.NUM_IRQ(8), .VECTOR_BASE(VBW), .VECTOR_STRIDE(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .irq_i(irq), .boundary_i(bnd), .rti_i(rti),
      .status_i(st_in), .pc_i(pc_in), .status_o(st_out_w), .status_we_o(swe_w),
      .pc_o(pc_out_w), .pc_we_o(pwe_w), .stall_o(stall_w), .irq_ack_o(ack_w),
      .in_handler_o(ih_w), .rti_err_o(err_w));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0]  irq;
      logic        bnd;
      logic        rti;
      status_t     st;
      logic [31:0] pc;
      logic [7:0]  e_ack;
      logic        e_stall;
      logic        e_we;
      status_t     e_st;
      logic [31:0] e_pc;
      logic        e_ih;
      logic        e_err;
      logic [31:0] e_pcw;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [7:0] i, logic b, logic r, status_t s, logic [31:0] p,
                               logic [7:0] a, logic sl, logic we, status_t es,
                               logic [31:0] ep, logic h, logic e, logic [31:0] epw);
      vec_t v;
      v.irq = i; v.bnd = b; v.rti = r; v.st = s; v.pc = p;
      v.e_ack = a; v.e_stall = sl; v.e_we = we; v.e_st = es; v.e_pc = ep;
      v.e_ih = h; v.e_err = e; v.e_pcw = epw;
      return v;
   endfunction

   task automatic drive_idle();
      irq = '0; bnd = 1'b0; rti = 1'b0; st_in = '0; pc_in = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: saved context plus a queue of writes owed to the core.
   typedef struct {
      status_t     st;
      logic [31:0] pc;
      logic        restore;
   } wr_t;

   wr_t         wq[$];
   logic        m_valid;
   status_t     m_st;
   logic [31:0] m_pc;

   task automatic model_step();
      logic [7:0]  e_ack = '0;
      logic        e_stall = 1'b0, e_we = 1'b0, e_err = 1'b0;
      status_t     e_st = '0;
      logic [31:0] e_pc = '0;
      logic        e_ih = m_valid;
      wr_t         w;
      if (wq.size() != 0) begin
         w = wq.pop_front();
         e_stall = 1'b1; e_we = 1'b1; e_st = w.st; e_pc = w.pc;
         if (w.restore) m_valid = 1'b0;
      end else if (rti && m_valid) begin
         e_stall = 1'b1;
         wq.push_back('{st: m_st, pc: m_pc, restore: 1'b1});
      end else if (rti) begin
         e_err = 1'b1;
      end else if (bnd && irq != 0 && !st_in.imask && !m_valid) begin
         int win = 0;
         while (!irq[win]) win++;
         e_ack = 8'(1 << win);
         e_stall = 1'b1;
         m_valid = 1'b1; m_st = st_in; m_pc = pc_in;
         wq.push_back('{st: '{alu_status: st_in.alu_status, imask: 1'b1, mode: SUPERVISOR},
                        pc: VB + 32'(win) * 32'd4, restore: 1'b0});
      end
      chk("rnd_ack", 32'(ack), 32'(e_ack));
      chk("rnd_stall", 32'(stall), 32'(e_stall));
      chk("rnd_status_we", 32'(swe), 32'(e_we));
      chk("rnd_pc_we", 32'(pwe), 32'(e_we));
      chk("rnd_status", 32'(st_out), 32'(e_st));
      chk("rnd_pc", pc_out, e_pc);
      chk("rnd_in_handler", 32'(ih), 32'(e_ih));
      chk("rnd_rti_err", 32'(err), 32'(e_err));
   endtask

   initial begin
      status_t stu, sts, sti;
      stu = '{alu_status: 4'b0101, imask: 1'b0, mode: USER};
      sts = '{alu_status: 4'b0101, imask: 1'b1, mode: SUPERVISOR};
      sti = '{alu_status: 4'b0000, imask: 1'b1, mode: USER};

      //          irq    b  r  st   pc      | ack    sl we e_st e_pc    ih err pcw
      tbl.push_back(mk(8'hFF, 1, 0, sti, 32'h0,   8'h00, 0, 0, '0,  32'h0,   0, 0, 32'h0));
      tbl.push_back(mk(8'h04, 1, 0, stu, 32'h100, 8'h04, 1, 0, '0,  32'h0,   0, 0, 32'h0));
      tbl.push_back(mk(8'h00, 0, 0, stu, 32'h100, 8'h00, 1, 1, sts, 32'h18,  1, 0, 32'h4));
      tbl.push_back(mk(8'h01, 1, 0, stu, 32'h18,  8'h00, 0, 0, '0,  32'h0,   1, 0, 32'h0));
      tbl.push_back(mk(8'h02, 1, 1, stu, 32'h18,  8'h00, 1, 0, '0,  32'h0,   1, 0, 32'h0));
      tbl.push_back(mk(8'h02, 1, 0, stu, 32'h18,  8'h00, 1, 1, stu, 32'h100, 1, 0, 32'h100));
      tbl.push_back(mk(8'h02, 1, 0, stu, 32'h100, 8'h02, 1, 0, '0,  32'h0,   0, 0, 32'h0));
      tbl.push_back(mk(8'h00, 0, 0, stu, 32'h100, 8'h00, 1, 1, sts, 32'h14,  1, 0, 32'h0));
      tbl.push_back(mk(8'h00, 0, 1, sts, 32'h14,  8'h00, 1, 0, '0,  32'h0,   1, 0, 32'h0));
      tbl.push_back(mk(8'h00, 0, 0, sts, 32'h14,  8'h00, 1, 1, stu, 32'h100, 1, 0, 32'h100));
      tbl.push_back(mk(8'h00, 0, 1, stu, 32'h100, 8'h00, 0, 0, '0,  32'h0,   0, 1, 32'h0));
      tbl.push_back(mk(8'hA0, 1, 0, stu, 32'h200, 8'h20, 1, 0, '0,  32'h0,   0, 0, 32'h0));
      tbl.push_back(mk(8'h00, 0, 0, stu, 32'h200, 8'h00, 1, 1, sts, 32'h24,  1, 0, 32'h10));
      tbl.push_back(mk(8'h00, 1, 0, stu, 32'h200, 8'h00, 0, 0, '0,  32'h0,   1, 0, 32'h0));

      // Held in reset with every line requesting at a boundary.
      rst_n = 1'b0;
      irq = 8'hFF; bnd = 1'b1; rti = 1'b0; st_in = stu; pc_in = 32'h100;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_we", 32'({swe, pwe}), 32'h0);
      chk("rst_outs", 32'(st_out) | pc_out, 32'h0);
      chk("rst_ih_err", 32'({ih, err}), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[k]) begin
         if (k != 0) @(negedge clk);
         irq = tbl[k].irq; bnd = tbl[k].bnd; rti = tbl[k].rti;
         st_in = tbl[k].st; pc_in = tbl[k].pc;
         #1;
         chk($sformatf("tbl%0d_ack", k), 32'(ack), 32'(tbl[k].e_ack));
         chk($sformatf("tbl%0d_stall", k), 32'(stall), 32'(tbl[k].e_stall));
         chk($sformatf("tbl%0d_status_we", k), 32'(swe), 32'(tbl[k].e_we));
         chk($sformatf("tbl%0d_pc_we", k), 32'(pwe), 32'(tbl[k].e_we));
         chk($sformatf("tbl%0d_status", k), 32'(st_out), 32'(tbl[k].e_st));
         chk($sformatf("tbl%0d_pc", k), pc_out, tbl[k].e_pc);
         chk($sformatf("tbl%0d_in_handler", k), 32'(ih), 32'(tbl[k].e_ih));
         chk($sformatf("tbl%0d_rti_err", k), 32'(err), 32'(tbl[k].e_err));
         chk($sformatf("tbl%0d_pc_wrap", k), pc_out_w, tbl[k].e_pcw);
      end

      // Reset asserted while the vector write is due.
      do_reset();
      irq = 8'h08; bnd = 1'b1; st_in = stu; pc_in = 32'h300;
      #1;
      chk("mid_ack", 32'(ack), 32'h08);
      @(negedge clk);
      drive_idle();
      #1;
      chk("mid_vector_we", 32'(swe), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 32'({swe, pwe}), 32'h0);
      chk("mid_rst_stall", 32'(stall), 32'h0);
      chk("mid_rst_ih", 32'(ih), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_after_we", 32'({swe, pwe, stall}), 32'h0);
      chk("mid_after_ih", 32'(ih), 32'h0);

      // Randomized run against the reference model.
      do_reset();
      wq.delete();
      m_valid = 1'b0; m_st = '0; m_pc = '0;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         irq   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         bnd   = 1'($urandom_range(0, 1));
         rti   = ($urandom_range(0, 5) == 0);
         st_in = '{alu_status: 4'($urandom), imask: ($urandom_range(0, 3) == 0),
                   mode: cpu_mode_e'($urandom_range(0, 1))};
         pc_in = $urandom;
         #1;
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
